// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                   |
// | Purpose  : Round-robin arbiter/sequencer placing two clients' operations |
// |            onto one shared, clocked 4-bit ALU and returning the result   |
// |            to the granted client with gnt/done pulses.                   |
// | Options  : ALU_ARB_STATS_EN adds saturating per-client grant counters    |
// |            (gcnt0/gcnt1).                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [1:0] sel0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] sel1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       ovf,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  output logic       alu_rst,
  input  logic [3:0] alu_out,
  input  logic       alu_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0] gcnt0,
  output logic [7:0] gcnt1
`endif
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  localparam logic [2:0] c_LAT = 3'(ALU_LATENCY);

  logic [1:0] r_state;
  logic [1:0] w_next;

  // r_last: 1 when client 1 was granted last, so client 0 wins the next tie
  logic       r_last;
  logic [2:0] r_cnt;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_sel;
  logic [3:0] r_result;
  logic       r_ovf;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_done0;
  logic       r_done1;
  logic       r_alu_rst;

  logic w_win0;
  logic w_win1;
  logic w_load;
  logic w_dec;
  logic w_capture;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one operation at a time, wait out the ALU latency, respond
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (req0 || req1) w_next = c_ISSUE;
      c_ISSUE: w_next = c_WAIT;
      c_WAIT:  if (r_cnt == 3'd1) w_next = c_RESP;
      c_RESP:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Per-state control strobes, including the round-robin winner decision
  always_comb begin
    w_win0    = 1'b0;
    w_win1    = 1'b0;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_win0 = req0 && (!req1 || r_last);
        w_win1 = req1 && (!req0 || !r_last);
      end
      c_ISSUE: w_load = 1'b1;
      c_WAIT: begin
        w_dec     = 1'b1;
        w_capture = (r_cnt == 3'd1);
      end
      default: ;
    endcase
  end

  // Operand capture, wait counter, result capture and handshake pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last    <= 1'b1;
      r_cnt     <= 3'd0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_sel     <= 2'd0;
      r_result  <= 4'd0;
      r_ovf     <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_alu_rst <= 1'b1;
    end else begin
      r_alu_rst <= 1'b0;
      r_gnt0    <= w_win0;
      r_gnt1    <= w_win1;
      r_done0   <= w_capture && !r_last;
      r_done1   <= w_capture && r_last;
      if (w_win0) begin
        r_a    <= a0;
        r_b    <= b0;
        r_sel  <= sel0;
        r_last <= 1'b0;
      end else if (w_win1) begin
        r_a    <= a1;
        r_b    <= b1;
        r_sel  <= sel1;
        r_last <= 1'b1;
      end
      if (w_load) begin
        r_cnt <= c_LAT;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture) begin
        r_result <= alu_out;
        r_ovf    <= alu_overflow;
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign result  = r_result;
  assign ovf     = r_ovf;
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sel = r_sel;
  assign alu_rst = r_alu_rst;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] r_gcnt0;
  logic [7:0] r_gcnt1;

  // Grant counters, one per client, sticking at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gcnt0 <= 8'd0;
      r_gcnt1 <= 8'd0;
    end else begin
      if (r_gnt0 && (r_gcnt0 != 8'hFF)) r_gcnt0 <= r_gcnt0 + 8'd1;
      if (r_gnt1 && (r_gcnt1 != 8'hFF)) r_gcnt1 <= r_gcnt1 + 8'd1;
    end
  end

  assign gcnt0 = r_gcnt0;
  assign gcnt1 = r_gcnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_arbiter                                                |
// | Purpose  : Self-checking bench for alu_arbiter. Two instances (latency 1 |
// |            and 3) each drive a behavioural ALU; a transaction-level      |
// |            model predicts grants, dones, operands and results.           |
// | Options  : ALU_ARB_STATS_EN also checks gcnt0/gcnt1.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

  localparam int NDUT = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  localparam int M_IDLE   = 0;
  localparam int M_MANUAL = 1;
  localparam int M_BOTH   = 2;
  localparam int M_RAND   = 3;
  localparam int M_ONLY0  = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rq   [NDUT][2];
  logic [3:0] ca   [NDUT][2];
  logic [3:0] cb   [NDUT][2];
  logic [1:0] cs   [NDUT][2];
  logic       g    [NDUT][2];
  logic       dn   [NDUT][2];
  logic [3:0] res  [NDUT];
  logic       ov   [NDUT];
  logic [3:0] aa   [NDUT];
  logic [3:0] ab   [NDUT];
  logic [1:0] asl  [NDUT];
  logic       arst [NDUT];
  logic [3:0] aout [NDUT];
  logic       aovf [NDUT];
  logic [4:0] pipe [NDUT][8];
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gc   [NDUT][2];
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int mode   = M_IDLE;
  int cyc    = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ALU_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req0(rq[0][0]), .a0(ca[0][0]), .b0(cb[0][0]), .sel0(cs[0][0]),
    .req1(rq[0][1]), .a1(ca[0][1]), .b1(cb[0][1]), .sel1(cs[0][1]),
    .gnt0(g[0][0]), .gnt1(g[0][1]), .done0(dn[0][0]), .done1(dn[0][1]),
    .result(res[0]), .ovf(ov[0]),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_sel(asl[0]), .alu_rst(arst[0]),
    .alu_out(aout[0]), .alu_overflow(aovf[0])
`ifdef ALU_ARB_STATS_EN
    , .gcnt0(gc[0][0]), .gcnt1(gc[0][1])
`endif
  );

  alu_arbiter #(.ALU_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0(rq[1][0]), .a0(ca[1][0]), .b0(cb[1][0]), .sel0(cs[1][0]),
    .req1(rq[1][1]), .a1(ca[1][1]), .b1(cb[1][1]), .sel1(cs[1][1]),
    .gnt0(g[1][0]), .gnt1(g[1][1]), .done0(dn[1][0]), .done1(dn[1][1]),
    .result(res[1]), .ovf(ov[1]),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_sel(asl[1]), .alu_rst(arst[1]),
    .alu_out(aout[1]), .alu_overflow(aovf[1])
`ifdef ALU_ARB_STATS_EN
    , .gcnt0(gc[1][0]), .gcnt1(gc[1][1])
`endif
  );

  // ALU behaviour: add (carry as overflow), subtract (borrow), and, xor
  function automatic logic [4:0] alu_f(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] s);
    case (s)
      2'd0:    alu_f = {1'b0, x} + {1'b0, y};
      2'd1:    alu_f = {x < y, 4'(x - y)};
      2'd2:    alu_f = {1'b0, x & y};
      default: alu_f = {1'b0, x ^ y};
    endcase
  endfunction

  // Clocked ALUs: result appears LAT edges after the operands are sampled
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      for (int j = 7; j > 0; j--) pipe[d][j] <= arst[d] ? 5'd0 : pipe[d][j-1];
      pipe[d][0] <= arst[d] ? 5'd0 : alu_f(aa[d], ab[d], asl[d]);
    end
  end
  assign aout[0] = pipe[0][LAT0-1][3:0];
  assign aovf[0] = pipe[0][LAT0-1][4];
  assign aout[1] = pipe[1][LAT1-1][3:0];
  assign aovf[1] = pipe[1][LAT1-1][4];

  // Transaction-level reference: when the arbiter is free and someone asks,
  // pick a winner and schedule the grant, completion and next free edge.
  int         lat    [NDUT] = '{LAT0, LAT1};
  int         since  [NDUT];
  int         nxt    [NDUT];
  int         gnt_e  [NDUT];
  int         done_e [NDUT];
  int         win    [NDUT];
  int         last   [NDUT];
  int         gcm    [NDUT][2];
  logic [4:0] pend   [NDUT];
  logic [4:0] held   [NDUT];
  logic [3:0] ha     [NDUT];
  logic [3:0] hb     [NDUT];
  logic [1:0] hs     [NDUT];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < NDUT; d++) begin
      if (!reset) begin
        since[d] = 0;  last[d] = 1;  nxt[d] = 0;  win[d] = 0;
        gnt_e[d] = -10;  done_e[d] = -10;
        ha[d] = 4'd0;  hb[d] = 4'd0;  hs[d] = 2'd0;
        held[d] = 5'd0;  pend[d] = 5'd0;
        gcm[d][0] = 0;  gcm[d][1] = 0;
      end else begin
        since[d] = since[d] + 1;
        if (gnt_e[d] == cyc - 1 && gcm[d][win[d]] < 255)
          gcm[d][win[d]] = gcm[d][win[d]] + 1;
        if (done_e[d] == cyc) held[d] = pend[d];
        if (cyc >= nxt[d] && (rq[d][0] || rq[d][1])) begin
          if (rq[d][0] && rq[d][1]) win[d] = (last[d] == 1) ? 0 : 1;
          else                      win[d] = rq[d][0] ? 0 : 1;
          ha[d]     = ca[d][win[d]];
          hb[d]     = cb[d][win[d]];
          hs[d]     = cs[d][win[d]];
          pend[d]   = alu_f(ha[d], hb[d], hs[d]);
          last[d]   = win[d];
          gnt_e[d]  = cyc;
          done_e[d] = cyc + 1 + lat[d];
          nxt[d]    = cyc + 3 + lat[d];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, cyc);
  endtask

  // Compare every output shortly after each active edge
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("d%0d_gnt%0d", d, c), 32'(g[d][c]),
            32'(reset && gnt_e[d] == cyc && win[d] == c));
        chk($sformatf("d%0d_done%0d", d, c), 32'(dn[d][c]),
            32'(reset && done_e[d] == cyc && win[d] == c));
`ifdef ALU_ARB_STATS_EN
        chk($sformatf("d%0d_gcnt%0d", d, c), 32'(gc[d][c]), 32'(gcm[d][c]));
`endif
      end
      chk($sformatf("d%0d_result", d), 32'(res[d]), 32'(held[d][3:0]));
      chk($sformatf("d%0d_ovf", d), 32'(ov[d]), 32'(held[d][4]));
      chk($sformatf("d%0d_alu_ops", d), {22'd0, aa[d], ab[d], asl[d]},
          {22'd0, ha[d], hb[d], hs[d]});
      chk($sformatf("d%0d_alu_rst", d), 32'(arst[d]), 32'(since[d] == 0));
    end
  end

  task automatic new_ops(input int d, input int c);
    ca[d][c] = 4'($urandom);
    cb[d][c] = 4'($urandom);
    cs[d][c] = 2'($urandom);
  endtask

  // One clock of client behaviour, applied on the falling edge
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < 2; c++) begin
        case (mode)
          M_IDLE:   rq[d][c] = 1'b0;
          M_MANUAL: if (g[d][c]) rq[d][c] = 1'b0;
          M_BOTH: begin
            rq[d][c] = 1'b1;
            if (g[d][c]) new_ops(d, c);
          end
          M_ONLY0: begin
            rq[d][c] = (c == 0);
            if (g[d][c]) new_ops(d, c);
          end
          default: begin
            if (rq[d][c] && g[d][c]) begin
              if ($urandom_range(1) == 0) rq[d][c] = 1'b0;
              else new_ops(d, c);
            end else if (!rq[d][c] && $urandom_range(2) == 0) begin
              rq[d][c] = 1'b1;
              new_ops(d, c);
            end
          end
        endcase
      end
    end
  endtask

  task automatic wait_done(input int d, input int c, input int budget);
    int n;
    n = 0;
    while (!dn[d][c] && n < budget) begin
      step();
      n++;
    end
    if (!dn[d][c]) chk($sformatf("d%0d_done%0d_timeout", d, c), 32'd0, 32'd1);
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < 2; c++) begin
        rq[d][c] = 1'b0;  ca[d][c] = 4'd0;  cb[d][c] = 4'd0;  cs[d][c] = 2'd0;
      end
    end

    // Reset held for 4 cycles, then idle with no requests
    repeat (4) step();
    reset = 1'b1;
    repeat (5) step();

    // Single operation from client 0: 1 + 1
    mode = M_MANUAL;
    for (int d = 0; d < NDUT; d++) begin
      rq[d][0] = 1'b1;  ca[d][0] = 4'd1;  cb[d][0] = 4'd1;  cs[d][0] = 2'd0;
    end
    wait_done(0, 0, 20);
    chk("single_res", 32'(res[0]), 32'd2);
    chk("single_ovf", 32'(ov[0]), 32'd0);
    wait_done(1, 0, 20);
    chk("single_res_l3", 32'(res[1]), 32'd2);

    // Overflowing add from client 1: 15 + 15
    for (int d = 0; d < NDUT; d++) begin
      rq[d][1] = 1'b1;  ca[d][1] = 4'hF;  cb[d][1] = 4'hF;  cs[d][1] = 2'd0;
    end
    wait_done(0, 1, 20);
    chk("ovf_res", 32'(res[0]), 32'hE);
    chk("ovf_flag", 32'(ov[0]), 32'd1);
    wait_done(1, 1, 20);
    repeat (3) step();
    chk("ovf_held", {27'd0, ov[1], res[1]}, 32'h1E);

    // Continuous contention from both clients
    mode = M_BOTH;
    repeat (40) step();

    // Abort an operation in flight with reset
    mode = M_IDLE;
    repeat (10) step();
    mode = M_MANUAL;
    for (int d = 0; d < NDUT; d++) begin
      rq[d][0] = 1'b1;
      new_ops(d, 0);
    end
    begin
      int n;
      n = 0;
      while (!g[0][0] && n < 20) begin
        step();
        n++;
      end
      if (!g[0][0]) chk("midop_gnt_timeout", 32'd0, 32'd1);
    end
    step();
    reset = 1'b0;
    repeat (2) step();
    mode = M_BOTH;
    for (int d = 0; d < NDUT; d++) begin
      rq[d][0] = 1'b1;  rq[d][1] = 1'b1;
    end
    reset = 1'b1;
    begin
      int n;
      n = 0;
      while (!g[0][0] && !g[0][1] && n < 10) begin
        step();
        n++;
      end
      chk("first_after_rst", {31'd0, g[0][0]}, 32'd1);
    end
    repeat (10) step();

    // Randomised traffic
    mode = M_RAND;
    repeat (1500) step();

`ifdef ALU_ARB_STATS_EN
    // Grant-counter saturation
    mode = M_IDLE;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    mode = M_ONLY0;
    repeat (1900) step();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_gcnt0_sat", d), 32'(gc[d][0]), 32'd255);
      chk($sformatf("d%0d_gcnt1_zero", d), 32'(gc[d][1]), 32'd0);
    end
`endif

    mode = M_IDLE;
    repeat (10) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
